// File: rtl/clock_div.sv
// Power-of-two clock divider: divClk is the MSB flop of a free-running STAGES-bit counter.
// Output moves clock-to-Q after a clk rise; async reset clears it with no edge; no flow control.
module clock_div #(
    parameter int STAGES = 1
) (
    output logic divClk,
    input  logic clk,
    input  logic rst_n
);

    if (STAGES < 1 || STAGES > 32) begin : g_bad_stages
        $error("clock_div: STAGES must be in 1..32");
    end

    // Power-up value keeps reset-less cascades defined in simulation.
    logic [STAGES-1:0] cnt_q = '0;
    logic [STAGES-1:0] cnt_d;

    assign cnt_d = cnt_q + STAGES'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign divClk = cnt_q[STAGES-1];

endmodule

// File: tb/tb_clock_div.sv
`timescale 1ns/1ps
// Bench for clock_div: STAGES 1/2/3 side by side plus a short ripple cascade of STAGES=1 taps.
module tb_clock_div;

    localparam int NC = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic div1, div2, div3;
    logic tap [NC];

    always #5 clk = ~clk;

    clock_div #(.STAGES(1)) u_s1 (.divClk(div1), .clk(clk), .rst_n(rst_n));
    clock_div #(.STAGES(2)) u_s2 (.divClk(div2), .clk(clk), .rst_n(rst_n));
    clock_div #(.STAGES(3)) u_s3 (.divClk(div3), .clk(clk), .rst_n(rst_n));

    for (genvar g = 0; g < NC; g++) begin : g_casc
        if (g == 0) begin : g_first
            clock_div #(.STAGES(1)) u_div (.divClk(tap[0]), .clk(clk), .rst_n(rst_n));
        end else begin : g_next
            clock_div #(.STAGES(1)) u_div (.divClk(tap[g]), .clk(tap[g-1]), .rst_n(rst_n));
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Period / high-time monitors
    time rise1 = 0, per1 = 0, hi1 = 0;
    time rise3 = 0, per3 = 0;
    time tap_rise [NC];
    time tap_per  [NC];

    always @(posedge div1) begin
        if (rise1 != 0) per1 = $time - rise1;
        rise1 = $time;
    end
    always @(negedge div1) begin
        if (rise1 != 0) hi1 = $time - rise1;
    end
    always @(posedge div3) begin
        if (rise3 != 0) per3 = $time - rise3;
        rise3 = $time;
    end
    for (genvar g = 0; g < NC; g++) begin : g_mon
        always @(posedge tap[g]) begin
            if (tap_rise[g] != 0) tap_per[g] = $time - tap_rise[g];
            tap_rise[g] = $time;
        end
    end

    typedef struct {
        logic       rst_n;
        logic [2:0] exp_div;   // {div3, div2, div1} after the edge
        logic [1:0] exp_cnt2;
    } vec_t;

    vec_t vecs [19];
    vec_t sbq  [$];

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n = v.rst_n;
        sbq.push_back(v);
        @(posedge clk);
        #2;
        e = sbq.pop_front();
        check1("div_vec", {29'd0, div3, div2, div1}, {29'd0, e.exp_div});
        check1("cnt2_vec", {30'd0, u_s2.cnt_q}, {30'd0, e.exp_cnt2});
    endtask

    initial begin
        int n;
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < NC; k++) begin
            tap_rise[k] = 0;
            tap_per[k]  = 0;
        end

        #1;
        check1("reset_state", {29'd0, div3, div2, div1}, 32'd0);

        // Three reset edges, then 16 counting edges
        vecs[0]  = '{1'b0, 3'b000, 2'd0};
        vecs[1]  = '{1'b0, 3'b000, 2'd0};
        vecs[2]  = '{1'b0, 3'b000, 2'd0};
        vecs[3]  = '{1'b1, 3'b001, 2'd1};
        vecs[4]  = '{1'b1, 3'b010, 2'd2};
        vecs[5]  = '{1'b1, 3'b011, 2'd3};
        vecs[6]  = '{1'b1, 3'b100, 2'd0};
        vecs[7]  = '{1'b1, 3'b101, 2'd1};
        vecs[8]  = '{1'b1, 3'b110, 2'd2};
        vecs[9]  = '{1'b1, 3'b111, 2'd3};
        vecs[10] = '{1'b1, 3'b000, 2'd0};
        vecs[11] = '{1'b1, 3'b001, 2'd1};
        vecs[12] = '{1'b1, 3'b010, 2'd2};
        vecs[13] = '{1'b1, 3'b011, 2'd3};
        vecs[14] = '{1'b1, 3'b100, 2'd0};
        vecs[15] = '{1'b1, 3'b101, 2'd1};
        vecs[16] = '{1'b1, 3'b110, 2'd2};
        vecs[17] = '{1'b1, 3'b111, 2'd3};
        vecs[18] = '{1'b1, 3'b000, 2'd0};
        for (int i = 0; i < 19; i++) apply(vecs[i]);

        // Async reset while STAGES=3 output is high
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check1("s3_high_before_rst", {31'd0, div3}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check1("async_clear_div", {29'd0, div3, div2, div1}, 32'd0);
        check1("async_clear_cnt3", {29'd0, u_s3.cnt_q}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        check1("held_after_async", {31'd0, div3}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (div3) begin
                n = i;
                break;
            end
        end
        check1("rise_edges_after_release", n, 4);

        // Reset held for 100 edges
        @(negedge clk); rst_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            check1("reset_held", {22'd0, tap[4], tap[3], tap[2], tap[1], tap[0],
                                  u_s3.cnt_q, u_s2.cnt_q}, 32'd0);
        end
        rise1 = 0; per1 = 0; hi1 = 0; rise3 = 0; per3 = 0;
        for (int k = 0; k < NC; k++) begin
            tap_rise[k] = 0;
            tap_per[k]  = 0;
        end

        // Free run for period and duty measurements
        @(negedge clk); rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #2;
        check1("s1_period_ns", 32'(per1), 32'd20);
        check1("s1_high_ns", 32'(hi1), 32'd10);
        check1("s3_period_ns", 32'(per3), 32'd80);
        for (int k = 0; k < NC; k++) begin
            check1($sformatf("tap%0d_period_ns", k + 1), 32'(tap_per[k]), 32'd10 << (k + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
